// File: rtl/radix4_mult_arbiter.sv
// Round-robin arbiter sharing one iterative 32x32 signed multiplier among N_REQ clients.
// A watchdog turns a result that never arrives into an error response.
module radix4_mult_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    output logic [N_REQ-1:0]           req_rdy,
    input  logic [32*N_REQ-1:0]        req_a,
    input  logic [32*N_REQ-1:0]        req_b,
    output logic [N_REQ-1:0]           rsp_vld,
    input  logic [N_REQ-1:0]           rsp_rdy,
    output logic [63:0]                rsp_c,
    output logic                       rsp_err,
    output logic                       m_vld_in,
    input  logic                       m_rdy_in,
    output logic [31:0]                m_a,
    output logic [31:0]                m_b,
    input  logic                       m_vld_out,
    output logic                       m_rdy_out,
    input  logic [63:0]                m_c,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       err_sticky
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic signed [31:0] m_a_q, m_a_d;
    logic signed [31:0] m_b_q, m_b_d;
    logic signed [63:0] rsp_c_q, rsp_c_d;
    logic               rsp_err_q, rsp_err_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               err_sticky_q, err_sticky_d;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    scan_idx;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            m_a_q        <= '0;
            m_b_q        <= '0;
            rsp_c_q      <= '0;
            rsp_err_q    <= 1'b0;
            wdog_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            m_a_q        <= m_a_d;
            m_b_q        <= m_b_d;
            rsp_c_q      <= rsp_c_d;
            rsp_err_q    <= rsp_err_d;
            wdog_q       <= wdog_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Search upward from rr_ptr, wrapping, so the last owner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!gnt_found && req_vld[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        m_a_d        = m_a_q;
        m_b_d        = m_b_q;
        rsp_c_d      = rsp_c_q;
        rsp_err_d    = rsp_err_q;
        wdog_d       = wdog_q;
        err_sticky_d = err_sticky_q;
        req_rdy      = '0;
        rsp_vld      = '0;
        m_vld_in     = 1'b0;
        m_rdy_out    = 1'b0;

        case (state_q)
            IDLE: begin
                // After a timeout the multiplier may still deliver a stale result; drain it here.
                m_rdy_out = err_sticky_q;
                if (gnt_found) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt_idx == ID_W'(i)) begin
                            req_rdy[i] = 1'b1;
                            m_a_d      = req_a[32*i +: 32];
                            m_b_d      = req_b[32*i +: 32];
                        end
                    end
                    grant_id_d = gnt_idx;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                m_vld_in = 1'b1;
                if (m_rdy_in) begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                m_rdy_out = 1'b1;
                if (m_vld_out) begin
                    rsp_c_d   = m_c;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                    if (WD_EN && wdog_q == WD_LAST) begin
                        rsp_c_d      = '0;
                        rsp_err_d    = 1'b1;
                        err_sticky_d = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant_id_q == ID_W'(i)) begin
                        rsp_vld[i] = 1'b1;
                        if (rsp_rdy[i]) begin
                            rr_ptr_d = ID_W'((i + 1) % N_REQ);
                            state_d  = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_a        = m_a_q;
    assign m_b        = m_b_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_err    = rsp_err_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != IDLE);
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_radix4_mult_arbiter.sv
// Bench for radix4_mult_arbiter: behavioural multiplier stub with adjustable latency,
// vector table of operations, and a scoreboard of expected responses.
module tb_radix4_mult_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic            CLK = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [32*N-1:0] req_a, req_b;
    logic [63:0]     rsp_c, m_c;
    logic            rsp_err, m_vld_in, m_rdy_in, m_vld_out, m_rdy_out, busy, err_sticky;
    logic [31:0]     m_a, m_b;
    logic [1:0]      grant_id;

    always #5 CLK = ~CLK;

    radix4_mult_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_c(rsp_c), .rsp_err(rsp_err),
        .m_vld_in(m_vld_in), .m_rdy_in(m_rdy_in), .m_a(m_a), .m_b(m_b),
        .m_vld_out(m_vld_out), .m_rdy_out(m_rdy_out), .m_c(m_c),
        .grant_id(grant_id), .busy(busy), .err_sticky(err_sticky)
    );

    // Multiplier stub: result appears mlat edges after the issue handshake.
    int          mlat = 3;
    int          st_cnt;
    int          st_s;
    logic [63:0] prod;
    always @(posedge CLK) begin
        if (rst) begin
            st_s <= 0; st_cnt <= 0; m_vld_out <= 1'b0; prod <= '0;
        end else begin
            case (st_s)
                0: if (m_vld_in && m_rdy_in) begin
                    prod   <= {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
                    st_cnt <= mlat;
                    st_s   <= 1;
                end
                1: if (st_cnt <= 1) begin st_s <= 2; m_vld_out <= 1'b1; end
                   else st_cnt <= st_cnt - 1;
                default: if (m_rdy_out) begin st_s <= 0; m_vld_out <= 1'b0; end
            endcase
        end
    end
    assign m_rdy_in = (st_s == 0);
    assign m_c      = prod;

    typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [63:0] c; logic err; int batch; } vec_t;
    typedef struct { int id; logic [63:0] c; logic err; } sb_t;

    localparam int NV = 13;
    vec_t        tbl [NV];
    sb_t         sb [$];
    int          gnt_log [$];
    logic [31:0] op_a [N][16];
    logic [31:0] op_b [N][16];
    logic [63:0] op_c [N][16];
    logic        op_e [N][16];
    int          op_n [N];
    int          op_k [N];
    logic [N-1:0] acc;
    int          m_rr, m_owner, cyc, hs_cyc, rsp_cyc, acc_cyc;
    logic [31:0] m_oa, m_ob;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    function automatic int arb(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic mon();
        logic [N-1:0] exp_rdy;
        sb_t e;
        cyc++;
        exp_rdy = '0;
        if (!busy && req_vld != '0) exp_rdy = N'(1) << arb(req_vld, m_rr);
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        acc = req_rdy & req_vld;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                sb.push_back('{i, op_c[i][op_k[i]], op_e[i][op_k[i]]});
                m_owner = i;
                m_oa    = op_a[i][op_k[i]];
                m_ob    = op_b[i][op_k[i]];
                acc_cyc = cyc;
                gnt_log.push_back(i);
            end
        end
        if (busy) chk("grant_id", 64'(grant_id), 64'(m_owner));
        if (m_vld_in) begin
            chk("m_a", 64'(m_a), 64'(m_oa));
            chk("m_b", 64'(m_b), 64'(m_ob));
            if (m_rdy_in) hs_cyc = cyc;
        end
        if (rsp_vld != '0) begin
            if (rsp_cyc < 0) rsp_cyc = cyc;
            if ((rsp_vld & rsp_rdy) != '0) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_vld=%b, expected no response", rsp_vld);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_vld", 64'(rsp_vld), 64'(N'(1) << e.id));
                    chk("rsp_c", rsp_c, e.c);
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    m_rr = (e.id + 1) % N;
                end
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) op_k[i]++;
            if (op_k[i] < op_n[i]) begin
                req_vld[i]        = 1'b1;
                req_a[32*i +: 32] = op_a[i][op_k[i]];
                req_b[32*i +: 32] = op_b[i][op_k[i]];
            end else begin
                req_vld[i]        = 1'b0;
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
            end
        end
        acc = '0;
    endtask

    task automatic cycle();
        @(negedge CLK);
        mon();
        @(posedge CLK);
        #1;
        drive();
    endtask

    task automatic add_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] c, input logic err);
        if (op_k[id] == op_n[id]) begin op_k[id] = 0; op_n[id] = 0; end
        op_a[id][op_n[id]] = a;
        op_b[id][op_n[id]] = b;
        op_c[id][op_n[id]] = c;
        op_e[id][op_n[id]] = err;
        op_n[id]++;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (op_k[i] != op_n[i]) return 1'b0;
        return (sb.size() == 0) && !busy;
    endfunction

    task automatic run_drain(input int budget, input string name);
        int t;
        t = 0;
        drive();
        while (t < budget && !all_done()) begin cycle(); t++; end
        if (!all_done()) bound_fail(name);
    endtask

    task automatic flush_bench();
        for (int i = 0; i < N; i++) begin op_n[i] = 0; op_k[i] = 0; end
        sb.delete();
        acc  = '0;
        m_rr = 0;
        drive();
    endtask

    initial begin
        int t;
        tbl[0]  = '{0, 32'd100, 32'd100, 64'd10000, 1'b0, 0};
        tbl[1]  = '{3, 32'd7, -32'sd9, -64'sd63, 1'b0, 1};
        tbl[2]  = '{0, 32'd3423, 32'd1123, 64'd3844029, 1'b0, 2};
        tbl[3]  = '{2, -32'sd7, 32'd6, -64'sd42, 1'b0, 2};
        tbl[4]  = '{3, -32'sd50000, 32'd40000, -64'sd2000000000, 1'b0, 3};
        tbl[5]  = '{0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 4};
        tbl[6]  = '{1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b0, 4};
        tbl[7]  = '{2, 32'd12345, -32'sd6789, -64'sd83810205, 1'b0, 4};
        tbl[8]  = '{3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 4};
        tbl[9]  = '{0, 32'd0, 32'd5, 64'd0, 1'b0, 4};
        tbl[10] = '{1, -32'sd32768, 32'd32767, -64'sd1073709056, 1'b0, 4};
        tbl[11] = '{2, 32'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4};
        tbl[12] = '{3, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0, 4};

        rst = 1'b1; rsp_rdy = '1; cyc = 0; m_owner = 0; m_oa = '0; m_ob = '0;
        hs_cyc = 0; rsp_cyc = -1; acc_cyc = 0;
        flush_bench();
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;

        @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_rsp_c", rsp_c, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_m_vld_in", 64'(m_vld_in), 64'd0);
        chk("rst_m_rdy_out", 64'(m_rdy_out), 64'd0);
        chk("rst_m_a", 64'(m_a), 64'd0);
        chk("rst_m_b", 64'(m_b), 64'd0);
        chk("rst_err_sticky", 64'(err_sticky), 64'd0);
        @(posedge CLK); #1;

        for (int bt = 0; bt < 5; bt++) begin
            for (int i = 0; i < NV; i++)
                if (tbl[i].batch == bt) add_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].err);
            gnt_log.delete();
            rsp_cyc = -1;
            run_drain(400, "table_drain");
            if (bt == 0) chk("min_latency", 64'(rsp_cyc - acc_cyc), 64'(3 + mlat));
        end
        chk("rr_order_len", 64'(gnt_log.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < gnt_log.size()) chk("rr_order", 64'(gnt_log[i]), 64'(i % N));

        // Response back-pressure while another requester waits.
        rsp_rdy = '0;
        add_op(1, -32'sd100, 32'd250, -64'sd25000, 1'b0);
        drive();
        t = 0;
        while (t < 50 && rsp_vld == '0) begin cycle(); t++; end
        if (rsp_vld == '0) bound_fail("bp_wait_rsp");
        add_op(2, 32'd77, 32'd3, 64'd231, 1'b0);
        drive();
        repeat (20) begin
            cycle();
            chk("bp_rsp_c", rsp_c, -64'sd25000);
            chk("bp_rsp_vld", 64'(rsp_vld), 64'b0010);
        end
        rsp_rdy = '1;
        run_drain(100, "bp_drain");

        // Watchdog: multiplier slower than the timeout; its late result must be drained.
        mlat = 20;
        rsp_cyc = -1;
        add_op(0, 32'd1234, 32'd5678, 64'd0, 1'b1);
        run_drain(100, "to_drain");
        chk("to_latency", 64'(rsp_cyc - hs_cyc), 64'(TO + 1));
        chk("to_sticky", 64'(err_sticky), 64'd1);
        chk("to_m_rdy_out_idle", 64'(m_rdy_out), 64'd1);
        repeat (10) cycle();
        chk("to_late_absorbed", 64'(m_vld_out), 64'd0);
        mlat = 3;
        add_op(1, 32'd9, 32'd9, 64'd81, 1'b0);
        run_drain(100, "to_after_drain");
        chk("to_sticky_kept", 64'(err_sticky), 64'd1);

        // Reset in the middle of WAIT.
        mlat = 10;
        add_op(2, 32'd11, 32'd11, 64'd121, 1'b0);
        drive();
        t = 0;
        while (t < 50 && !(busy && m_rdy_out)) begin cycle(); t++; end
        if (!(busy && m_rdy_out)) bound_fail("rst_wait_state");
        cycle(); cycle();
        rst = 1'b1;
        @(posedge CLK); #1;
        rst = 1'b0;
        flush_bench();
        @(negedge CLK);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("midrst_grant_id", 64'(grant_id), 64'd0);
        chk("midrst_sticky", 64'(err_sticky), 64'd0);
        chk("midrst_rsp_c", rsp_c, 64'd0);
        @(posedge CLK); #1;
        mlat = 3;
        add_op(0, 32'd5, -32'sd3, -64'sd15, 1'b0);
        add_op(3, 32'd2, 32'd2, 64'd4, 1'b0);
        run_drain(100, "midrst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
